// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory master.
// SPI_MEM_MASTER_VERIFY_EN adds the VGAP state used by write readback.
package spi_mem_pkg;

    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned FRAME_W = 16;
    localparam logic        RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
`ifdef SPI_MEM_MASTER_VERIFY_EN
        ,
        VGAP
`endif
    } state_e;

    // Reads carry zero data bits on mosi.
    function automatic logic [FRAME_W-1:0] make_frame(input logic [ADDR_W-1:0] addr,
                                                      input logic              rw,
                                                      input logic [DATA_W-1:0] data);
        return {addr, rw, (rw == RW_READ) ? {DATA_W{1'b0}} : data};
    endfunction

endpackage

// File: rtl/spi_mem_sclk_gen.sv
// SPI clock generator: toggles sclk every CLK_DIV cycles while enabled, idles low.
// rise/fall flag the clk edge on which sclk is about to change.
module spi_mem_sclk_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    logic [7:0] cnt;
    logic       wrap;

    assign wrap = en && (cnt == 8'(CLK_DIV - 1));
    assign rise = wrap && !sclk;
    assign fall = wrap && sclk;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/spi_mem_master.sv
// SPI mode-0 master issuing single-byte read/write frames to spiMemory.
// Define SPI_MEM_MASTER_VERIFY_EN to read back every write and flag mismatches.
module spi_mem_master
    import spi_mem_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              verify_err,
    output logic              sclk_pin,
    output logic              cs_pin,
    output logic              mosi_pin,
    input  logic              miso_pin
);

    state_e               state;
    logic [15:0]          cnt;
    logic [3:0]           bit_cnt;
    logic [FRAME_W-1:0]   frame;
    logic [DATA_W-1:0]    rx;
    logic                 rd;
    logic                 sclk_rise;
    logic                 sclk_fall;
    logic                 half_done;
    logic                 gap_done;

`ifdef SPI_MEM_MASTER_VERIFY_EN
    logic                 vfy;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
`else
    assign verify_err = 1'b0;
`endif

    assign half_done = (cnt == 16'(CLK_DIV - 1));
    assign gap_done  = (cnt == 16'(CS_GAP - 1));
    assign mosi_pin  = frame[FRAME_W-1];

    spi_mem_sclk_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .en     (state == SHIFT),
        .sclk   (sclk_pin),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            frame      <= '0;
            rx         <= '0;
            rd         <= 1'b0;
            cs_pin     <= 1'b1;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
`ifdef SPI_MEM_MASTER_VERIFY_EN
            vfy        <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            verify_err <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        frame     <= make_frame(req_addr, ~req_write, req_wdata);
                        rd        <= ~req_write;
                        cs_pin    <= 1'b0;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        state     <= SETUP;
`ifdef SPI_MEM_MASTER_VERIFY_EN
                        vfy        <= 1'b0;
                        addr_q     <= req_addr;
                        wdata_q    <= req_wdata;
                        verify_err <= 1'b0;
`endif
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    if (half_done) begin
                        cnt     <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                SHIFT: begin
                    // Data phase of a read: slave bit is stable across the rising edge.
                    if (sclk_rise && rd && bit_cnt[3]) begin
                        rx <= {rx[DATA_W-2:0], miso_pin};
                    end
                    if (sclk_fall) begin
                        frame   <= {frame[FRAME_W-2:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd15) begin
                            cnt   <= '0;
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        cnt    <= '0;
                        cs_pin <= 1'b1;
`ifdef SPI_MEM_MASTER_VERIFY_EN
                        if (!rd) begin
                            state <= VGAP;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rx;
                            if (vfy) verify_err <= (rx != wdata_q);
                            state <= GAP;
                        end
`else
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rd ? rx : '0;
                        state     <= GAP;
`endif
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        cnt       <= '0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`ifdef SPI_MEM_MASTER_VERIFY_EN
                VGAP: begin
                    if (gap_done) begin
                        frame  <= make_frame(addr_q, RW_READ, '0);
                        rd     <= 1'b1;
                        vfy    <= 1'b1;
                        cs_pin <= 1'b0;
                        cnt    <= '0;
                        state  <= SETUP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master with a behavioural spiMemory slave and a reference memory.
// Build with SPI_MEM_MASTER_VERIFY_EN to also exercise write readback.
module tb_spi_mem_master;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned CS_GAP  = 4;
    localparam int          LAT     = 34 * CLK_DIV;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [6:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       verify_err;
    logic       sclk_pin;
    logic       cs_pin;
    logic       mosi_pin;
    bit         miso_pin;
    bit         fault;

    always #5 clk = ~clk;

    spi_mem_master #(
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .verify_err(verify_err),
        .sclk_pin  (sclk_pin),
        .cs_pin    (cs_pin),
        .mosi_pin  (mosi_pin),
        .miso_pin  (miso_pin)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // spiMemory slave: commits a write only once a full 16-bit frame has been seen.
    bit [7:0]  mem [128];
    bit [15:0] sh;
    bit [15:0] obs_frame;
    int        rise_cnt = 0;
    int        obs_rises = 0;
    int        frame_cnt = 0;
    bit        s_rw;
    bit [7:0]  s_out;

    always @(posedge sclk_pin or posedge cs_pin) begin
        if (cs_pin) begin
            if (rise_cnt == 16) begin
                obs_frame <= sh;
                frame_cnt <= frame_cnt + 1;
                if (sh[8] == 1'b0)
                    mem[sh[15:9]] <= (fault && sh[15:9] == 7'h20) ? ~sh[7:0] : sh[7:0];
            end
            if (rise_cnt != 0) obs_rises <= rise_cnt;
            rise_cnt <= 0;
        end else begin
            sh       <= {sh[14:0], mosi_pin};
            rise_cnt <= rise_cnt + 1;
            if (rise_cnt == 7) begin
                s_rw  <= mosi_pin;
                s_out <= mem[sh[6:0]];
            end
        end
    end

    always @(negedge sclk_pin) begin
        if (!cs_pin && s_rw && rise_cnt >= 8 && rise_cnt < 16)
            miso_pin <= s_out[3'(15 - rise_cnt)];
    end

    // Protocol monitors, sampled on pre-edge values.
    int   cyc = 0;
    int   cs_low = 0;
    int   ready_err = 0;
    int   mode_err = 0;
    logic p_s = 1'b0;
    logic p_m = 1'b0;
    int   acc_cyc[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        p_s <= sclk_pin;
        p_m <= mosi_pin;
        if (p_s && sclk_pin && p_m != mosi_pin) mode_err <= mode_err + 1;
        if (!cs_pin && req_ready) ready_err <= ready_err + 1;
        if (!cs_pin) cs_low <= cs_low + 1;
        if (reset_n && req_valid && req_ready) acc_cyc.push_back(cyc);
    end

    bit [7:0] ref_mem [128];

    function automatic int exp_frame(input bit wr, input bit [6:0] a, input bit [7:0] d);
`ifdef SPI_MEM_MASTER_VERIFY_EN
        if (wr) return int'(a) * 512 + 256;
`endif
        return int'(a) * 512 + (wr ? 0 : 256) + (wr ? int'(d) : 0);
    endfunction

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        ok = req_ready;
    endtask

    // exp_rd: read data for reads, expected readback for writes.
    task automatic txn(input bit wr, input bit [6:0] a, input bit [7:0] d,
                       input bit [7:0] exp_rd, input bit exp_verr, input string tag);
        int lat, c0, f0, e_lat, e_cs, e_data;
        bit got, ok;
        e_lat  = LAT;
        e_cs   = LAT;
        e_data = wr ? 0 : int'(exp_rd);
`ifdef SPI_MEM_MASTER_VERIFY_EN
        if (wr) begin
            e_lat  = 2 * LAT + CS_GAP;
            e_cs   = 2 * LAT;
            e_data = int'(exp_rd);
        end
`endif
        wait_ready(ok);
        if (!ok) begin
            check({tag, " ready timeout"}, 0, 1);
            return;
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        c0 = cs_low;
        f0 = frame_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 4 * LAT) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) got = 1'b1;
        end
        check({tag, " latency"}, got ? lat : -1, e_lat);
        check({tag, " rdata"}, int'(rsp_rdata), e_data);
        check({tag, " verify_err"}, int'(verify_err), int'(exp_verr));
        check({tag, " frame"}, int'(obs_frame), exp_frame(wr, a, d));
        check({tag, " sclk rises"}, obs_rises, 16);
        check({tag, " cs low cycles"}, cs_low - c0, e_cs);
        check({tag, " frames"}, frame_cnt - f0, e_cs / LAT);
        @(posedge clk);
        #1 check({tag, " rsp pulse width"}, int'(rsp_valid), 0);
        if (wr) ref_mem[a] = d;
    endtask

    typedef struct {
        bit       wr;
        bit [6:0] a;
        bit [7:0] d;
        bit [7:0] exp_rd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n0, n_rsp, f0, t;
        bit [6:0] a;
        bit [7:0] d;
        bit wr;

        vecs[0] = '{1'b1, 7'h15, 8'hA5, 8'hA5};
        vecs[1] = '{1'b0, 7'h15, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 7'h01, 8'h5A, 8'h5A};
        vecs[3] = '{1'b0, 7'h01, 8'h00, 8'h5A};
        vecs[4] = '{1'b0, 7'h7F, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 7'h7F, 8'hFF, 8'hFF};

        // Reset values
        repeat (3) @(negedge clk);
        check("reset cs_pin", int'(cs_pin), 1);
        check("reset sclk_pin", int'(sclk_pin), 0);
        check("reset mosi_pin", int'(mosi_pin), 0);
        check("reset req_ready", int'(req_ready), 0);
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset rsp_rdata", int'(rsp_rdata), 0);
        check("reset verify_err", int'(verify_err), 0);
        reset_n = 1'b1;
        #1 check("ready before first edge", int'(req_ready), 0);
        @(posedge clk);
        #1 check("ready after release", int'(req_ready), 1);

        for (int i = 0; i < 6; i++)
            txn(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rd, 1'b0, $sformatf("vec%0d", i));

        // Back-to-back: valid held high across two requests
        wait_ready(ok);
        n0 = acc_cyc.size();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h33;
        req_wdata = 8'h77;
        t = 0;
        while (acc_cyc.size() == n0 && t < 100) begin
            @(posedge clk);
            #1 t++;
        end
        req_write = 1'b0;
        req_addr  = 7'h33;
        req_wdata = 8'h00;
        t = 0;
        while (acc_cyc.size() < n0 + 2 && t < 1000) begin
            @(posedge clk);
            #1 t++;
        end
        req_valid = 1'b0;
        if (acc_cyc.size() >= n0 + 2) begin
`ifdef SPI_MEM_MASTER_VERIFY_EN
            check("b2b accept spacing", acc_cyc[n0+1] - acc_cyc[n0], 2 * LAT + 2 * CS_GAP + 1);
`else
            check("b2b accept spacing", acc_cyc[n0+1] - acc_cyc[n0], LAT + CS_GAP + 1);
`endif
        end else begin
            check("b2b second accept", acc_cyc.size() - n0, 2);
        end
        t = 0;
        while (!rsp_valid && t < 4 * LAT) begin
            @(posedge clk);
            #1 t++;
        end
        check("b2b read latency", t, LAT);
        check("b2b read rdata", int'(rsp_rdata), 8'h77);
        ref_mem[7'h33] = 8'h77;

        // Reset during bit 5 of SHIFT: aborted write to 7'h01 must not land
        wait_ready(ok);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 7'h01;
        req_wdata = 8'hFF;
        f0 = frame_cnt;
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0;
        while (rise_cnt < 6 && t < 2 * LAT) begin
            @(posedge clk);
            #1 t++;
        end
        check("abort reached bit 5", rise_cnt, 6);
        #2 reset_n = 1'b0;
        #1;
        check("abort cs_pin", int'(cs_pin), 1);
        check("abort sclk_pin", int'(sclk_pin), 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        n_rsp = 0;
        repeat (2 * LAT) begin
            @(posedge clk);
            #1 if (rsp_valid) n_rsp++;
        end
        check("abort no rsp_valid", n_rsp, 0);
        check("abort no frame committed", frame_cnt - f0, 0);
        txn(1'b0, 7'h01, 8'h00, ref_mem[7'h01], 1'b0, "read after abort");

        // Randomised traffic against the reference memory
        for (int i = 0; i < 16; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            d  = 8'($urandom_range(0, 255));
            if (a == 7'h20) a = 7'h40;
            txn(wr, a, d, wr ? d : ref_mem[a], 1'b0, $sformatf("rand%0d", i));
        end

`ifdef SPI_MEM_MASTER_VERIFY_EN
        fault = 1'b1;
        txn(1'b1, 7'h20, 8'h3C, 8'hC3, 1'b1, "verify faulty write");
        ref_mem[7'h20] = 8'hC3;
        fault = 1'b0;
        txn(1'b1, 7'h21, 8'h11, 8'h11, 1'b0, "verify clean write");
`endif

        check("req_ready never high with cs low", ready_err, 0);
        check("mosi stable while sclk high", mode_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
